axis_pkt_packer: RTL and testbench
==================================

Name: axis_pkt_packer

Overview:
- Parametrised successor to the network processor's AXI-Stream input stage.
- Accepts a narrow AXI-Stream bus of BUS_WIDTH bits and assembles multi-beat packets of PKT_WIDTH bits, MSB-first.
- Buffers completed packets in a FIFO of FIFO_DEPTH entries and presents them on a PKT_WIDTH-wide AXI-Stream master that feeds network_source.
- Adds tlast framing, partial-packet abort, a drop counter and FIFO level visibility; the single-beat wrapper had none of these.

Parameters:
- BUS_WIDTH, 8: s_axis data width in bits, >= 1.
- PKT_WIDTH, 24: packet width in bits, >= 1. NBEATS = ceil(PKT_WIDTH/BUS_WIDTH).
- FIFO_DEPTH, 4: packet FIFO entries, >= 2, any integer (not restricted to a power of 2).
- TLAST_ABORT, 1: 1 = s_axis_tlast on a non-final beat discards the partial packet; 0 = tlast is ignored except on the final beat.
- CNT_WIDTH, 8: width of drop_count.

Ports:
- clk  in  1  clock, all logic on rising edge.
- arstn  in  1  reset; synchronous, active-low.
- s_axis_tdata  in  BUS_WIDTH  input beat.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when tvalid && tready.
- s_axis_tlast  in  1  frame end marker.
- m_axis_tdata  out  PKT_WIDTH  head-of-FIFO packet.
- m_axis_tvalid  out  1  FIFO non-empty.
- m_axis_tready  in  1  downstream accept.
- m_axis_tlast  out  1  head packet's stored tlast flag.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  occupied FIFO entries.
- drop_count  out  CNT_WIDTH  aborted partial packets, saturating.

Behaviour:
- Reset (arstn=0 at a clk edge):
  - Clears beat counter, assembly register, FIFO pointers, fifo_level and drop_count.
  - While arstn=0: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - Reset mid-packet discards any partial packet; the first beat after reset is beat 0.
- Assembly FSM: state is beat index k in 0..NBEATS-1.
  - Beat k is written to assembly bits [(NBEATS-k)*BUS_WIDTH-1 -: BUS_WIDTH].
  - Packet = assembly[NBEATS*BUS_WIDTH-1 -: PKT_WIDTH]. Packets are left-justified; excess LSBs of the final beat are dropped.
  - Handshake on k<NBEATS-1:
    - Without tlast, or with TLAST_ABORT=0: k <= k+1.
    - With tlast and TLAST_ABORT=1: k <= 0, partial data discarded, drop_count <= min(drop_count+1, 2^CNT_WIDTH-1).
  - Handshake on k=NBEATS-1: the packet {assembled MSBs, final beat} is written to the FIFO with tlast flag = s_axis_tlast; k <= 0.
  - NBEATS=1: every beat is a final beat; the abort path never fires.
- s_axis_tready:
  - = arstn && (k != NBEATS-1 || fifo_level < FIFO_DEPTH).
  - No combinational path from m_axis_tready; a pop frees space from the next cycle onward.
- Latency: the final-beat handshake at edge t gives m_axis_tvalid=1 after edge t (1 cycle) if the FIFO was empty. Otherwise the packet is queued in order.
- FIFO:
  - m_axis_tvalid = (fifo_level != 0).
  - m_axis_tdata/tlast show the head entry, stable while tvalid && !tready.
  - Pop on m_axis_tvalid && m_axis_tready.
  - Push and pop in the same cycle: level unchanged, order preserved; the push is only possible when level < FIFO_DEPTH.
  - Pointers wrap at FIFO_DEPTH-1 -> 0.
- When the FIFO is full, non-final beats continue to be accepted. Stall occurs only at the final beat.

Test Plan (BUS_WIDTH=8, PKT_WIDTH=20, NBEATS=3, FIFO_DEPTH=4, TLAST_ABORT=1, CNT_WIDTH=2):
1. Beats 0xAB,0xCD,0xEF, tlast on 0xEF, m_axis_tready=1 -> one cycle after the third handshake: m_axis_tdata=0xABCDE, m_axis_tlast=1, tvalid for exactly 1 cycle, fifo_level returns to 0.
2. m_axis_tready=0, send 4 packets plus 2 beats of a 5th -> fifo_level=4, tready=1 for those 2 beats, tready=0 at the 5th's final beat. Pulse m_axis_tready 1 cycle -> first packet popped, tready=1 next cycle, 5th packet accepted, level=4.
3. Beat 0x11 with tlast, then 0x22,0x33,0x44 -> no output for 0x11, drop_count=1; single output 0x22334.
4. At fifo_level=2, final beat handshake coincides with a pop -> level stays 2; output order equals input order across pointer wrap (send 10 packets with random m_axis_tready).
5. Deassert arstn after beat 0x55 of a packet -> all outputs 0, tready=0 during reset. After release, beats 0x01,0x02,0x03 -> output 0x01020.
6. Four aborts (tlast on beat 0) -> drop_count reads 1,2,3,3 (saturation), FIFO untouched.

Source files
------------

// File: rtl/axis_pkt_packer.sv
// axis_pkt_packer: packs narrow AXI-Stream beats into wide packets and queues them in a FIFO
module axis_pkt_packer #(
  parameter int BUS_WIDTH   = 8,
  parameter int PKT_WIDTH   = 24,
  parameter int FIFO_DEPTH  = 4,
  parameter int TLAST_ABORT = 1,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                            clk,
  input  logic                            arstn,
  input  logic [BUS_WIDTH-1:0]            s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [PKT_WIDTH-1:0]            m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic [CNT_WIDTH-1:0]            drop_count
);
  localparam int NBEATS = (PKT_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int AW     = NBEATS * BUS_WIDTH;
  localparam int KW     = NBEATS > 1 ? $clog2(NBEATS) : 1;
  localparam int LW     = $clog2(FIFO_DEPTH + 1);
  localparam int PW     = $clog2(FIFO_DEPTH);
  logic [KW-1:0]      k;
  logic [AW-1:0]      asm_q, asm_nxt;
  logic [PKT_WIDTH:0] mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic               last_beat, s_hs, push, pop, abort;
  assign last_beat     = k == KW'(NBEATS - 1);
  assign s_axis_tready = arstn && (!last_beat || fifo_level < LW'(FIFO_DEPTH));
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign push          = s_hs && last_beat;
  assign abort         = s_hs && !last_beat && s_axis_tlast && TLAST_ABORT != 0;
  assign m_axis_tvalid = arstn && fifo_level != '0;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr][PKT_WIDTH-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid && mem[rd_ptr][PKT_WIDTH];
  // drop the current beat into its MSB-first slot of the assembly word
  always_comb begin
    asm_nxt = asm_q;
    for (int b = 0; b < NBEATS; b++)
      asm_nxt[(NBEATS-b)*BUS_WIDTH-1 -: BUS_WIDTH] = int'(k) == b ? s_axis_tdata : asm_q[(NBEATS-b)*BUS_WIDTH-1 -: BUS_WIDTH];
  end
  // beat index, assembly register and saturating abort counter
  always_ff @(posedge clk) begin
    if (!arstn) begin
      k          <= '0;
      asm_q      <= '0;
      drop_count <= '0;
    end else if (s_hs) begin
      k          <= last_beat || abort ? '0 : k + KW'(1);
      asm_q      <= asm_nxt;
      if (abort && drop_count != '1) drop_count <= drop_count + CNT_WIDTH'(1);
    end
  end
  // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged
  always_ff @(posedge clk) begin
    if (!arstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + PW'(1);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end
  // FIFO storage holds the left-justified packet plus its tlast flag
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_axis_tlast, asm_nxt[AW-1 -: PKT_WIDTH]};
  end
endmodule

// File: tb/tb_axis_pkt_packer.sv
// tb_axis_pkt_packer: directed self-checking bench for axis_pkt_packer
module tb_axis_pkt_packer;
  localparam int BW = 8, PW = 20, DEPTH = 4, CW = 2;
  logic          clk = 0, arstn = 0;
  logic [BW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 0, s_axis_tready, s_axis_tlast = 0;
  logic [PW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready = 0, m_axis_tlast;
  logic [2:0]    fifo_level;
  logic [CW-1:0] drop_count;
  int            checks = 0, errors = 0;
  logic [PW:0]   expq [$];
  axis_pkt_packer #(.BUS_WIDTH(BW), .PKT_WIDTH(PW), .FIFO_DEPTH(DEPTH), .TLAST_ABORT(1), .CNT_WIDTH(CW)) dut (
    .clk(clk), .arstn(arstn), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .fifo_level(fifo_level), .drop_count(drop_count));
  always #5 clk = ~clk;
  function automatic logic [PW:0] pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic l);
    logic [23:0] w;
    w = {b0, b1, b2};
    return {l, w[23:4]};
  endfunction
  task automatic send_beat(input logic [7:0] d, input logic l);
    bit done;
    done = 0;
    s_axis_tdata = d; s_axis_tlast = l; s_axis_tvalid = 1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    s_axis_tvalid = 0; s_axis_tlast = 0;
    if (!done) begin errors++; $display("FAIL send_beat timeout data=%h", d); end
  endtask
  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic l);
    expq.push_back(pkt(b0, b1, b2, l));
    send_beat(b0, 0); send_beat(b1, 0); send_beat(b2, l);
  endtask
  task automatic drain();
    logic [PW:0] e;
    m_axis_tready = 1;
    for (int i = 0; i < 200 && expq.size() > 0; i++) begin
      if (m_axis_tvalid) begin
        e = expq.pop_front();
        checks++;
        if ({m_axis_tlast, m_axis_tdata} !== e) begin errors++; $display("FAIL drain got=%h exp=%h", {m_axis_tlast, m_axis_tdata}, e); end
      end
      @(posedge clk); #1;
    end
    m_axis_tready = 0;
    checks++;
    if (expq.size() != 0) begin errors++; $display("FAIL drain timeout left=%0d exp=0", expq.size()); expq.delete(); end
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata}); end
    checks++;
    if (fifo_level !== 0 || drop_count !== 0) begin errors++; $display("FAIL reset_regs level=%0d drop=%0d exp=0,0", fifo_level, drop_count); end
    arstn = 1; #1;
    checks++;
    if (s_axis_tready !== 1) begin errors++; $display("FAIL reset_release tready=%b exp=1", s_axis_tready); end
  endtask
  task automatic test_single();
    m_axis_tready = 1;
    send_beat(8'hAB, 0); send_beat(8'hCD, 0); send_beat(8'hEF, 1);
    checks++;
    if (m_axis_tvalid !== 1 || m_axis_tdata !== 20'hABCDE || m_axis_tlast !== 1) begin errors++; $display("FAIL single_out v=%b d=%h l=%b exp=1,abcde,1", m_axis_tvalid, m_axis_tdata, m_axis_tlast); end
    @(posedge clk); #1;
    checks++;
    if (m_axis_tvalid !== 0 || fifo_level !== 0) begin errors++; $display("FAIL single_pop v=%b level=%0d exp=0,0", m_axis_tvalid, fifo_level); end
    m_axis_tready = 0;
  endtask
  task automatic test_full();
    logic [PW:0] e;
    for (int i = 0; i < 4; i++) send_pkt(8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i), 1'(i));
    checks++;
    if (fifo_level !== 4) begin errors++; $display("FAIL full_level got=%0d exp=4", fifo_level); end
    expq.push_back(pkt(8'h5A, 8'h5B, 8'h5C, 1));
    send_beat(8'h5A, 0); send_beat(8'h5B, 0);
    s_axis_tdata = 8'h5C; s_axis_tlast = 1; s_axis_tvalid = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (s_axis_tready !== 0 || fifo_level !== 4) begin errors++; $display("FAIL full_stall tready=%b level=%0d exp=0,4", s_axis_tready, fifo_level); end
    @(posedge clk); #1;
    m_axis_tready = 1;
    e = expq.pop_front();
    checks++;
    if ({m_axis_tlast, m_axis_tdata} !== e) begin errors++; $display("FAIL full_head got=%h exp=%h", {m_axis_tlast, m_axis_tdata}, e); end
    @(posedge clk); #1;
    m_axis_tready = 0;
    checks++;
    if (fifo_level !== 3 || s_axis_tready !== 1) begin errors++; $display("FAIL full_pop level=%0d tready=%b exp=3,1", fifo_level, s_axis_tready); end
    @(posedge clk); #1;
    s_axis_tvalid = 0; s_axis_tlast = 0;
    checks++;
    if (fifo_level !== 4) begin errors++; $display("FAIL full_refill level=%0d exp=4", fifo_level); end
    drain();
  endtask
  task automatic test_abort();
    send_beat(8'h11, 1);
    checks++;
    if (drop_count !== 1 || fifo_level !== 0 || m_axis_tvalid !== 0) begin errors++; $display("FAIL abort drop=%0d level=%0d v=%b exp=1,0,0", drop_count, fifo_level, m_axis_tvalid); end
    send_pkt(8'h22, 8'h33, 8'h44, 0);
    checks++;
    if (fifo_level !== 1 || m_axis_tdata !== 20'h22334) begin errors++; $display("FAIL abort_pkt level=%0d d=%h exp=1,22334", fifo_level, m_axis_tdata); end
    drain();
  endtask
  task automatic test_back_to_back();
    logic [PW:0] e;
    int got;
    send_pkt(8'hA1, 8'hA2, 8'hA3, 0);
    send_pkt(8'hB1, 8'hB2, 8'hB3, 1);
    expq.push_back(pkt(8'hC1, 8'hC2, 8'hC3, 0));
    send_beat(8'hC1, 0); send_beat(8'hC2, 0);
    s_axis_tdata = 8'hC3; s_axis_tvalid = 1; m_axis_tready = 1;
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1 || fifo_level !== 2) begin errors++; $display("FAIL concurrent_pre tready=%b level=%0d exp=1,2", s_axis_tready, fifo_level); end
    @(posedge clk); #1;
    s_axis_tvalid = 0; m_axis_tready = 0;
    e = expq.pop_front();
    checks++;
    if (fifo_level !== 2 || {m_axis_tlast, m_axis_tdata} !== expq[0]) begin errors++; $display("FAIL concurrent level=%0d head=%h exp=2,%h", fifo_level, {m_axis_tlast, m_axis_tdata}, expq[0]); end
    drain();
    got = 0;
    fork
      for (int p = 0; p < 10; p++) send_pkt(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      for (int i = 0; i < 3000 && got < 10; i++) begin
        @(posedge clk); #1;
        m_axis_tready = 1'($urandom_range(0, 1));
        if (m_axis_tvalid && m_axis_tready) begin
          e = expq.pop_front();
          got++;
          checks++;
          if ({m_axis_tlast, m_axis_tdata} !== e) begin errors++; $display("FAIL order pkt=%0d got=%h exp=%h", got, {m_axis_tlast, m_axis_tdata}, e); end
        end
      end
    join
    @(posedge clk); #1;
    m_axis_tready = 0;
    checks++;
    if (got != 10 || fifo_level !== 0) begin errors++; $display("FAIL order_count got=%0d level=%0d exp=10,0", got, fifo_level); end
  endtask
  task automatic test_reset_mid();
    send_pkt(8'h61, 8'h62, 8'h63, 0);
    send_beat(8'h55, 0);
    arstn = 0; #1;
    checks++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== '0) begin errors++; $display("FAIL midreset_outputs got=%h exp=0", {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata}); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (fifo_level !== 0 || drop_count !== 0 || s_axis_tready !== 0) begin errors++; $display("FAIL midreset_regs level=%0d drop=%0d tready=%b exp=0,0,0", fifo_level, drop_count, s_axis_tready); end
    arstn = 1;
    expq.delete();
    send_pkt(8'h01, 8'h02, 8'h03, 1);
    checks++;
    if (m_axis_tdata !== 20'h01020 || fifo_level !== 1) begin errors++; $display("FAIL midreset_pkt d=%h level=%0d exp=01020,1", m_axis_tdata, fifo_level); end
    drain();
  endtask
  task automatic test_saturate();
    logic [CW-1:0] exp_d [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    for (int i = 0; i < 4; i++) begin
      send_beat(8'h70 + 8'(i), 1);
      checks++;
      if (drop_count !== exp_d[i] || fifo_level !== 0) begin errors++; $display("FAIL saturate abort=%0d drop=%0d level=%0d exp=%0d,0", i, drop_count, fifo_level, exp_d[i]); end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_full();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
